// File: rtl/clk_div_prog_if.sv
// Control and output bundle of the programmable clock divider: global enable/sync,
// per-channel divisor load requests, and per-channel clk_out/tick/div_ack outputs.
interface clk_div_prog_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
);
    logic                      en;
    logic                      sync;
    logic [CHANNELS*WIDTH-1:0] div_val;
    logic [CHANNELS-1:0]       div_load;
    logic [CHANNELS-1:0]       div_ack;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       tick;

    modport master (
        output en, sync, div_val, div_load,
        input  div_ack, clk_out, tick
    );

    modport slave (
        input  en, sync, div_val, div_load,
        output div_ack, clk_out, tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider with glitch-free divisor reload and sync.
// Optional CLK_DIV_ODD_DUTY50_EN: odd divisors >= 3 get exact 50% duty via a negedge stage.
module clk_div_prog #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input logic           clk,
    input logic           reset,
    clk_div_prog_if.slave bus
);

    logic [CHANNELS-1:0] clk_out_w;
    logic [CHANNELS-1:0] tick_w;
    logic [CHANNELS-1:0] ack_w;

    // Number of high cycles of the posedge-registered term for divisor n.
    function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] n);
`ifdef CLK_DIV_ODD_DUTY50_EN
        if (n[0] && (n > WIDTH'(2)))
            return {1'b0, n} >> 1;
`endif
        return ({1'b0, n} + (WIDTH+1)'(1)) >> 1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] n_reg, n_next;
            logic [WIDTH-1:0] k_reg, k_next;
            logic [WIDTH-1:0] pend_reg, pend_next;
            logic             pend_vld_reg, pend_vld_next;
            logic             run_reg, run_next;
            logic             tick_reg, tick_next;
            logic             ack_reg, ack_next;
            logic             a_reg, a_next;
            logic             boundary;

            always_comb begin
                n_next        = n_reg;
                k_next        = k_reg;
                pend_next     = pend_reg;
                pend_vld_next = pend_vld_reg;
                run_next      = run_reg;
                tick_next     = 1'b0;
                ack_next      = 1'b0;
                a_next        = a_reg;
                boundary      = 1'b0;

                if (bus.sync || bus.en) begin
                    // A new period starts on sync, on the first enabled edge, while idle
                    // (N=0), or when the last phase of the current period is left.
                    if (bus.sync || !run_reg || (n_reg == '0))
                        boundary = 1'b1;
                    else if (k_reg == (n_reg - WIDTH'(1)))
                        boundary = 1'b1;

                    if (boundary && pend_vld_reg) begin
                        n_next        = pend_reg;
                        pend_vld_next = 1'b0;
                        ack_next      = 1'b1;
                    end

                    if (boundary) begin
                        k_next    = '0;
                        tick_next = (n_next != '0);
                    end else begin
                        k_next = k_reg + WIDTH'(1);
                    end

                    run_next = 1'b1;
                    a_next   = ({1'b0, k_next} < high_len(n_next));
                end

                // Loads are captured even while disabled; the latest one wins.
                if (bus.div_load[gi]) begin
                    pend_next     = bus.div_val[gi*WIDTH +: WIDTH];
                    pend_vld_next = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    n_reg        <= WIDTH'(DEFAULT_DIV);
                    k_reg        <= '0;
                    pend_reg     <= '0;
                    pend_vld_reg <= 1'b0;
                    run_reg      <= 1'b0;
                    tick_reg     <= 1'b0;
                    ack_reg      <= 1'b0;
                    a_reg        <= 1'b0;
                end else begin
                    n_reg        <= n_next;
                    k_reg        <= k_next;
                    pend_reg     <= pend_next;
                    pend_vld_reg <= pend_vld_next;
                    run_reg      <= run_next;
                    tick_reg     <= tick_next;
                    ack_reg      <= ack_next;
                    a_reg        <= a_next;
                end
            end

`ifdef CLK_DIV_ODD_DUTY50_EN
            // Half-cycle extension of the high phase, only for odd divisors >= 3.
            logic b_reg;
            always_ff @(negedge clk or posedge reset) begin
                if (reset)
                    b_reg <= 1'b0;
                else
                    b_reg <= a_reg & n_reg[0] & (n_reg > WIDTH'(2));
            end
            assign clk_out_w[gi] = a_reg | b_reg;
`else
            assign clk_out_w[gi] = a_reg;
`endif
            assign tick_w[gi] = tick_reg;
            assign ack_w[gi]  = ack_reg;
        end
    endgenerate

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;
    assign bus.div_ack = ack_w;

endmodule
